// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: the fetch FSM state type and the instruction
// words that the fetch path treats specially (reset NOP and default halt word).
package rv32i_pkg;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_WAIT   = 2'd1,
        FS_DONE   = 2'd2,
        FS_HALTED = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR_DEF = 32'h0000_0073;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
        return addr_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// WAIT-cycle counter for the fetch unit; flags the last permitted cycle of a
// memory wait so the FSM can abort the fetch on that edge.
module fetch_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last_cycle
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // True during the WAIT cycle whose increment would reach TIMEOUT_CYC.
    assign last_cycle = (count_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one memory read per fetch request, halt/fault detection.
// Optional wait timeout is compiled in with `define FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instrfetch,
    input  logic [31:0] pc,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic        instr_fetched,
    output logic        halt,
    output logic        fetch_fault
);
    fetch_state_e state_q, state_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  instr_q, instr_d;
    logic         fetched_q, fetched_d;
    logic         halt_q, halt_d;
    logic         fault_q, fault_d;
    logic         timeout_hit;

    if (TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("instr_fetch_unit: TIMEOUT_CYC must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        ((state_q == FS_IDLE) && instrfetch && is_word_aligned(pc[1:0])),
        .inc        ((state_q == FS_WAIT) && !imem_ready),
        .last_cycle (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        fetched_d = 1'b0;
        halt_d    = halt_q;
        fault_d   = fault_q;
        case (state_q)
            FS_IDLE: begin
                if (instrfetch) begin
                    if (is_word_aligned(pc[1:0])) begin
                        addr_d  = pc;
                        req_d   = 1'b1;
                        state_d = FS_WAIT;
                    end else begin
                        fault_d = 1'b1;
                        halt_d  = 1'b1;
                        state_d = FS_HALTED;
                    end
                end
            end
            FS_WAIT: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    // A request withdrawn mid-wait still lands the word but is not reported.
                    if (instrfetch) begin
                        fetched_d = 1'b1;
                        halt_d    = halt_q | (imem_rdata == HALT_INSTR);
                        state_d   = FS_DONE;
                    end else begin
                        state_d = FS_IDLE;
                    end
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    halt_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = FS_HALTED;
                end
            end
            FS_DONE: begin
                state_d = (instr_q == HALT_INSTR) ? FS_HALTED : FS_IDLE;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FS_IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            instr_q   <= NOP_INSTR;
            fetched_q <= 1'b0;
            halt_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            fetched_q <= fetched_d;
            halt_q    <= halt_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign instr         = instr_q;
    assign instr_fetched = fetched_q;
    assign halt          = halt_q;
    assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand-written
// multi-cycle sequences, and randomized fetches against a transaction-level model.
module tb_instr_fetch_unit;
    import rv32i_pkg::*;

    localparam int TO = 16;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instrfetch = 1'b0;
    logic [31:0] pc = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_fetched;
    logic        halt;
    logic        fetch_fault;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.TIMEOUT_CYC(TO), .HALT_INSTR(HALT_INSTR_DEF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instrfetch    (instrfetch),
        .pc            (pc),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .instr         (instr),
        .instr_fetched (instr_fetched),
        .halt          (halt),
        .fetch_fault   (fetch_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          waits;
        bit          drop;
        int          exp_lat;
        int          exp_pulses;
        bit          exp_req;
        logic [31:0] exp_instr;
        bit          exp_halt;
        bit          exp_fault;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        instrfetch = 1'b0;
        imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One fetch: instrfetch raised for one request, memory answers after 'waits' idle WAIT cycles.
    task automatic run_fetch(input logic [31:0] p, input logic [31:0] data, input int waits,
                             input bit drop, output int lat, output int npulse,
                             output bit saw_req, output bit addr_ok, output bit halt_at);
        int wcnt = 0;
        lat = -1; npulse = 0; saw_req = 1'b0; addr_ok = 1'b1; halt_at = 1'b0;
        @(negedge clk);
        instrfetch = 1'b1;
        pc         = p;
        imem_rdata = data;
        imem_ready = 1'b0;
        for (int k = 1; k <= waits + 8; k++) begin
            @(negedge clk);
            if (imem_req) begin
                saw_req = 1'b1;
                if (imem_addr !== p) addr_ok = 1'b0;
            end
            if (instr_fetched) begin
                npulse++;
                if (lat < 0) begin
                    lat     = k;
                    halt_at = halt;
                end
            end
            if (drop || !imem_req) instrfetch = 1'b0;
            imem_ready = imem_req && (wcnt == waits);
            if (imem_req && wcnt < waits) wcnt++;
        end
        instrfetch = 1'b0;
        imem_ready = 1'b0;
    endtask

    task automatic check_fetch(input string tag, input vec_t v, input int lat, input int npulse,
                               input bit saw_req, input bit addr_ok, input bit halt_at);
        check({tag, " pulses"}, 32'(npulse), 32'(v.exp_pulses));
        if (v.exp_pulses > 0) begin
            check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
            check({tag, " halt_with_pulse"}, {31'd0, halt_at}, {31'd0, v.exp_halt});
        end
        check({tag, " req_seen"}, {31'd0, saw_req}, {31'd0, v.exp_req});
        if (v.exp_req) check({tag, " addr_stable"}, {31'd0, addr_ok}, 32'd1);
        check({tag, " instr"}, instr, v.exp_instr);
        check({tag, " halt"}, {31'd0, halt}, {31'd0, v.exp_halt});
        check({tag, " fault"}, {31'd0, fetch_fault}, {31'd0, v.exp_fault});
        check({tag, " req_idle"}, {31'd0, imem_req}, 32'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        vec_t        v;
        int          lat, npulse;
        bit          saw_req, addr_ok, halt_at;
        logic [31:0] m_instr;
        bit          m_halt, m_fault;
        logic [31:0] r;
        int          pulse_k[$];
        bit          any_req;

        vecs.push_back('{32'h0000_0004, 32'h0050_0093, 0, 1'b0, 2, 1, 1'b1, 32'h0050_0093, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0100, 32'h1234_5678, 3, 1'b0, 5, 1, 1'b1, 32'h1234_5678, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0006, 32'h1111_1111, 0, 1'b0, 0, 0, 1'b0, NOP_INSTR,     1'b1, 1'b1});
        vecs.push_back('{32'h0000_0008, 32'h0000_0073, 0, 1'b0, 2, 1, 1'b1, 32'h0000_0073, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0020, 32'h0A0A_0A0A, 2, 1'b1, 0, 0, 1'b1, 32'h0A0A_0A0A, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFFC, 32'hDEAD_BEEF, 1, 1'b0, 3, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0});
`ifdef FETCH_TIMEOUT_EN
        vecs.push_back('{32'h0000_0040, 32'hCAFE_F00D, 15, 1'b0, 17, 1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0040, 32'hCAFE_F00D, 16, 1'b0, 0, 0, 1'b1, NOP_INSTR,     1'b1, 1'b1});
`else
        vecs.push_back('{32'h0000_0040, 32'hCAFE_F00D, 20, 1'b0, 22, 1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0});
`endif

        // Reset values
        do_reset();
        check("rst imem_req", {31'd0, imem_req}, 32'd0);
        check("rst imem_addr", imem_addr, 32'd0);
        check("rst instr", instr, NOP_INSTR);
        check("rst instr_fetched", {31'd0, instr_fetched}, 32'd0);
        check("rst halt", {31'd0, halt}, 32'd0);
        check("rst fault", {31'd0, fetch_fault}, 32'd0);

        // imem_ready outside WAIT has no effect
        imem_ready = 1'b1;
        imem_rdata = 32'h7777_7777;
        repeat (3) @(negedge clk);
        imem_ready = 1'b0;
        check("idle_ready instr", instr, NOP_INSTR);
        check("idle_ready fetched", {31'd0, instr_fetched}, 32'd0);

        foreach (vecs[i]) begin
            v = vecs[i];
            do_reset();
            run_fetch(v.pc, v.data, v.waits, v.drop, lat, npulse, saw_req, addr_ok, halt_at);
            $display("vec %0d pc=%h waits=%0d drop=%0d lat=%0d pulses=%0d instr=%h halt=%0d fault=%0d",
                     i, v.pc, v.waits, v.drop, lat, npulse, instr, halt, fetch_fault);
            check_fetch($sformatf("vec%0d", i), v, lat, npulse, saw_req, addr_ok, halt_at);
        end

        // Misaligned fault, then further requests must be ignored
        do_reset();
        run_fetch(32'h0000_0006, 32'h0, 0, 1'b0, lat, npulse, saw_req, addr_ok, halt_at);
        any_req = 1'b0;
        npulse  = 0;
        instrfetch = 1'b1; pc = 32'h0000_0040; imem_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (imem_req) any_req = 1'b1;
            if (instr_fetched) npulse++;
        end
        instrfetch = 1'b0; imem_ready = 1'b0;
        $display("halted-ignore req=%0d pulses=%0d halt=%0d", any_req, npulse, halt);
        check("halted_ignore req", {31'd0, any_req}, 32'd0);
        check("halted_ignore pulses", 32'(npulse), 32'd0);
        check("halted_ignore halt", {31'd0, halt}, 32'd1);

        // Asynchronous reset in the middle of WAIT
        do_reset();
        @(negedge clk);
        instrfetch = 1'b1; pc = 32'h0000_0010; imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("midwait req", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midwait_rst req", {31'd0, imem_req}, 32'd0);
        check("midwait_rst addr", imem_addr, 32'd0);
        check("midwait_rst instr", instr, NOP_INSTR);
        check("midwait_rst fetched", {31'd0, instr_fetched}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; instrfetch = 1'b0;
        any_req = 1'b0; npulse = 0;
        repeat (4) begin
            @(negedge clk);
            if (imem_req) any_req = 1'b1;
            if (instr_fetched) npulse++;
        end
        $display("reset-midwait req=%0d pulses=%0d instr=%h", any_req, npulse, instr);
        check("midwait_after req", {31'd0, any_req}, 32'd0);
        check("midwait_after pulses", 32'(npulse), 32'd0);

        // Back-to-back fetches with instrfetch held high
        do_reset();
        @(negedge clk);
        instrfetch = 1'b1; pc = 32'h0000_0080; imem_rdata = 32'h1357_9BDF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (instr_fetched) pulse_k.push_back(k);
            imem_ready = imem_req;
        end
        instrfetch = 1'b0; imem_ready = 1'b0;
        $display("back-to-back pulses=%0d", pulse_k.size());
        check("b2b npulses_ge2", {31'd0, pulse_k.size() >= 2}, 32'd1);
        if (pulse_k.size() >= 2) begin
            check("b2b first", 32'(pulse_k[0]), 32'd2);
            check("b2b second", 32'(pulse_k[1]), 32'd5);
        end
        check("b2b instr", instr, 32'h1357_9BDF);
        repeat (4) @(negedge clk);

        // Randomized fetch stream against a transaction-level model
        do_reset();
        m_instr = NOP_INSTR; m_halt = 1'b0; m_fault = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (m_halt && $urandom_range(0, 1) == 1) begin
                do_reset();
                m_instr = NOP_INSTR; m_halt = 1'b0; m_fault = 1'b0;
            end
            r      = $urandom();
            v.pc   = ($urandom_range(0, 7) == 0) ? r : {r[31:2], 2'b00};
            v.data = ($urandom_range(0, 9) == 0) ? HALT_INSTR_DEF : $urandom();
            v.waits = $urandom_range(0, 20);
            v.drop  = ($urandom_range(0, 5) == 0);
            v.exp_lat = 2 + v.waits;
            v.exp_pulses = 0;
            if (m_halt) begin
                v.exp_req = 1'b0;
            end else if (v.pc[1:0] != 2'b00) begin
                v.exp_req = 1'b0; m_halt = 1'b1; m_fault = 1'b1;
            end else if (TIMEOUT_EN && v.waits >= TO) begin
                v.exp_req = 1'b1; m_halt = 1'b1; m_fault = 1'b1;
            end else begin
                v.exp_req = 1'b1;
                m_instr = v.data;
                if (!v.drop) begin
                    v.exp_pulses = 1;
                    if (v.data == HALT_INSTR_DEF) m_halt = 1'b1;
                end
            end
            v.exp_instr = m_instr; v.exp_halt = m_halt; v.exp_fault = m_fault;
            run_fetch(v.pc, v.data, v.waits, v.drop, lat, npulse, saw_req, addr_ok, halt_at);
            $display("rnd %0d pc=%h data=%h waits=%0d drop=%0d lat=%0d pulses=%0d halt=%0d fault=%0d",
                     t, v.pc, v.data, v.waits, v.drop, lat, npulse, halt, fetch_fault);
            check_fetch($sformatf("rnd%0d", t), v, lat, npulse, saw_req, addr_ok, halt_at);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, max WAIT cycles before fetch fault (used only when the timeout feature is compiled in).
REQ-002 Parameter HALT_INSTR, default 32'h0000_0073 (ECALL), instruction word that stops the core.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 instrfetch  in  1  fetch request level from the control FSM, held high while the FSM is in its IF state.
REQ-006 pc  in  32  byte address of the instruction to fetch.
REQ-007 imem_ready  in  1  instruction memory data-valid strobe.
REQ-008 imem_rdata  in  32  instruction memory read data, valid when imem_ready=1.
REQ-009 imem_req  out  1  registered memory read request.
REQ-010 imem_addr  out  32  registered memory address, stable while imem_req=1.
REQ-011 instr  out  32  last fetched instruction word, held until the next capture.
REQ-012 instr_fetched  out  1  one-cycle completion pulse to the control FSM.
REQ-013 halt  out  1  sticky stop indication to the control FSM.
REQ-014 fetch_fault  out  1  sticky error flag (misaligned pc, or timeout).

Function
REQ-015 FSM states SHALL be IDLE, WAIT, DONE, HALTED; all outputs registered.
REQ-016 IDLE: instrfetch=1 with pc[1:0]=0 -> imem_addr<=pc, imem_req<=1, next WAIT.
REQ-017 IDLE: instrfetch=1 with pc[1:0]!=0 -> fetch_fault<=1, halt<=1, no memory request, next HALTED.
REQ-018 WAIT: imem_req stays 1 and imem_addr stays stable until imem_ready=1.
REQ-019 WAIT with imem_ready=1: instr<=imem_rdata, imem_req<=0, next DONE.
REQ-020 imem_ready SHALL be ignored in every state other than WAIT.
REQ-021 DONE: instr_fetched=1 for exactly one cycle; next IDLE, or HALTED if instr==HALT_INSTR.
REQ-022 halt SHALL assert in the same cycle as the instr_fetched pulse that delivers HALT_INSTR.
REQ-023 Latency: with zero-wait memory, instr_fetched rises 2 cycles after instrfetch is first sampled high; each extra memory wait cycle adds 1.
REQ-024 instrfetch dropping during WAIT: the fetch SHALL complete and instr SHALL update, but instr_fetched SHALL NOT pulse; next IDLE.
REQ-025 instrfetch still high in IDLE immediately after DONE SHALL start a new fetch (back-to-back fetches allowed).
REQ-026 HALTED is absorbing until reset: imem_req=0, instr_fetched=0, halt=1.
REQ-027 instrfetch=1 while in HALTED SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL force, asynchronously: state IDLE, imem_req 0, imem_addr 0, instr 32'h0000_0013 (NOP), instr_fetched 0, halt 0, fetch_fault 0, timeout counter 0.
REQ-029 Reset asserted during WAIT SHALL abandon the transaction; imem_req SHALL drop with no completion pulse.
REQ-030 After rst_n deasserts, the first fetch SHALL start on the first edge at which instrfetch=1.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN defined: a counter SHALL clear on WAIT entry and increment each WAIT cycle without imem_ready; on reaching TIMEOUT_CYC -> fetch_fault<=1, halt<=1, imem_req<=0, next HALTED.
REQ-032 imem_ready=1 in the same cycle the count reaches TIMEOUT_CYC SHALL win: normal capture, no fault.
REQ-033 Macro FETCH_TIMEOUT_EN undefined: no counter logic; WAIT persists indefinitely; fetch_fault arises only from misalignment.

Structure
REQ-034 Shared package rv32i_pkg SHALL hold the fetch state enum, NOP_INSTR (32'h0000_0013) and the HALT_INSTR default constant.
REQ-035 Timeout counter width SHALL be $clog2(TIMEOUT_CYC+1).
REQ-036 Timeout counter SHALL be sub-module fetch_timeout_ctr, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-037 Zero-wait fetch: pc=0x04, imem_rdata=0x00500093, ready in first WAIT cycle -> instr=0x00500093, instr_fetched single pulse 2 cycles after instrfetch.
REQ-038 Wait states: ready after 3 WAIT cycles -> imem_addr held at pc throughout, pulse at cycle 5, imem_req drops after capture.
REQ-039 Misaligned: pc=0x06 -> fetch_fault=1, halt=1, imem_req never asserted, later instrfetch ignored.
REQ-040 Halt instruction: imem_rdata=0x00000073 -> halt and instr_fetched assert in same cycle, HALTED until rst_n low.
REQ-041 Timeout (FETCH_TIMEOUT_EN, TIMEOUT_CYC=16): ready never asserted -> fault and halt after 16 WAIT cycles; repeat with ready on cycle 16 -> normal capture.
REQ-042 Reset mid-WAIT: rst_n low for 1 cycle -> all outputs at reset values immediately, instr=0x00000013, no pulse.
